// File: rtl/controlador_contexto_pkg.sv
// ---------------------------------------------------------------------------
// controlador_contexto_pkg
// Shared encodings for the context-switch controller: trap cause codes as
// seen by the control unit and the CPU top, plus the controller state codes.
// ---------------------------------------------------------------------------
package controlador_contexto_pkg;

  // Trap cause codes reported on trap_cause
  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_QUANTUM = 3'd1;
  localparam logic [2:0] CAUSE_IO      = 3'd2;
  localparam logic [2:0] CAUSE_OUT     = 3'd3;
  localparam logic [2:0] CAUSE_END     = 3'd4;
  localparam logic [2:0] CAUSE_FAULT   = 3'd5;

  // Controller states
  localparam logic [1:0] ST_OS   = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_TRAP = 2'd2;

endpackage

// File: rtl/controlador_contexto_decodificador_regiao.sv
// ---------------------------------------------------------------------------
// controlador_contexto_decodificador_regiao
// Maps a PC onto the owning process id using a chain of constant compares
// against the region boundaries, so no divider is needed.
//   i_pc      PC to classify
//   o_procId  0 for the OS region, 1..NUM_PROC for user regions
//   o_isUser  PC is at or above the first user region
//   o_fault   PC is past the last user region
// ---------------------------------------------------------------------------
module controlador_contexto_decodificador_regiao
  import controlador_contexto_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int NUM_PROC    = 10,
  parameter int OS_LIMIT    = 300,
  parameter int REGION_SIZE = 300
) (
  input  logic [PC_W-1:0] i_pc,
  output logic [7:0]      o_procId,
  output logic            o_isUser,
  output logic            o_fault
);

  localparam logic [PC_W-1:0] USER_END = PC_W'(OS_LIMIT + NUM_PROC * REGION_SIZE);

  // w_geBound is a thermometer code: bit k set when pc has reached region k
  logic [NUM_PROC-1:0] w_geBound;

  for (genvar k = 0; k < NUM_PROC; k++) begin : g_bound
    localparam logic [PC_W-1:0] BOUND = PC_W'(OS_LIMIT + k * REGION_SIZE);
    assign w_geBound[k] = (i_pc >= BOUND);
  end

  // Counting the thermometer bits gives the 1-based region number directly
  always_comb begin
    o_procId = 8'd0;
    for (int k = 0; k < NUM_PROC; k++) begin
      if (w_geBound[k]) o_procId = o_procId + 8'd1;
    end
  end

  assign o_isUser = w_geBound[0];
  assign o_fault  = (i_pc >= USER_END);

endmodule

// File: rtl/controlador_contexto.sv
// ---------------------------------------------------------------------------
// controlador_contexto
// Context-switch controller: tracks the running process from the PC region,
// counts its quantum and raises one trap request at a time, holding vector,
// cause and resume PC stable until the CPU acknowledges.
//   clock, reset   system clock, asynchronous active-high reset
//   enable         CPU advanced this cycle
//   pc             current PC
//   io_req/out_req/end_req  instruction events decoded this cycle
//   quantum_cfg    runtime quantum (0 selects QUANTUM)
//   trap_ack       CPU has taken the trap
//   trap_valid/trap_vector/trap_cause/saved_pc  pending trap request
//   proc_id        running process id (0 = OS), one cycle behind pc
//   quantum_left   remaining quantum
//   in_user        controller is in the RUN state
// ---------------------------------------------------------------------------
module controlador_contexto
  import controlador_contexto_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int NUM_PROC    = 10,
  parameter int OS_LIMIT    = 300,
  parameter int REGION_SIZE = 300,
  parameter int QUANTUM     = 16,
  parameter int QW          = 8,
  parameter int VEC_SAVE    = 180,
  parameter int VEC_IO      = 92,
  parameter int VEC_OUT     = 160,
  parameter int VEC_END     = 233
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [PC_W-1:0] pc,
  input  logic            io_req,
  input  logic            out_req,
  input  logic            end_req,
  input  logic [QW-1:0]   quantum_cfg,
  input  logic            trap_ack,
  output logic            trap_valid,
  output logic [PC_W-1:0] trap_vector,
  output logic [2:0]      trap_cause,
  output logic [PC_W-1:0] saved_pc,
  output logic [7:0]      proc_id,
  output logic [QW-1:0]   quantum_left,
  output logic            in_user
);

  logic [1:0]      r_state;
  logic [PC_W-1:0] r_trapVector;
  logic [2:0]      r_trapCause;
  logic [PC_W-1:0] r_savedPc;
  logic [7:0]      r_procId;
  logic [QW-1:0]   r_quantum;

  logic [7:0]      w_procId;
  logic            w_isUser;
  logic            w_fault;
  logic            w_trapReq;
  logic [2:0]      w_cause;
  logic [PC_W-1:0] w_vector;
  logic [PC_W-1:0] w_savedPc;
  logic [PC_W-1:0] w_pcNext;
  logic [QW-1:0]   w_quantumInit;

  controlador_contexto_decodificador_regiao #(
    .PC_W        (PC_W),
    .NUM_PROC    (NUM_PROC),
    .OS_LIMIT    (OS_LIMIT),
    .REGION_SIZE (REGION_SIZE)
  ) u_decodificador (
    .i_pc     (pc),
    .o_procId (w_procId),
    .o_isUser (w_isUser),
    .o_fault  (w_fault)
  );

  assign w_pcNext      = pc + PC_W'(1);
  assign w_quantumInit = (quantum_cfg != '0) ? quantum_cfg : QW'(QUANTUM);

  // Trap arbitration: instruction events outrank quantum expiry, so an
  // expiry coinciding with an event is dropped rather than queued.
  always_comb begin
    w_trapReq = 1'b0;
    w_cause   = CAUSE_NONE;
    w_vector  = '0;
    w_savedPc = '0;
    if (r_state == ST_RUN && enable) begin
      if (w_fault) begin
        w_trapReq = 1'b1;
        w_cause   = CAUSE_FAULT;
        w_vector  = PC_W'(VEC_END);
        w_savedPc = pc;
      end else if (end_req) begin
        w_trapReq = 1'b1;
        w_cause   = CAUSE_END;
        w_vector  = PC_W'(VEC_END);
        w_savedPc = w_pcNext;
      end else if (out_req) begin
        w_trapReq = 1'b1;
        w_cause   = CAUSE_OUT;
        w_vector  = PC_W'(VEC_OUT);
        w_savedPc = w_pcNext;
      end else if (io_req) begin
        w_trapReq = 1'b1;
        w_cause   = CAUSE_IO;
        w_vector  = PC_W'(VEC_IO);
        w_savedPc = w_pcNext;
      end else if (r_quantum == QW'(1)) begin
        w_trapReq = 1'b1;
        w_cause   = CAUSE_QUANTUM;
        w_vector  = PC_W'(VEC_SAVE);
        w_savedPc = pc;
      end
    end
  end

  // FSM, quantum counter and trap registers. proc_id follows pc except while
  // a trap is pending (so the trapped process stays visible) or when pc is
  // outside every region (the last valid id is kept).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_OS;
      r_trapVector <= '0;
      r_trapCause  <= CAUSE_NONE;
      r_savedPc    <= '0;
      r_procId     <= '0;
      r_quantum    <= '0;
    end else begin
      if (r_state != ST_TRAP && !w_fault) r_procId <= w_procId;
      case (r_state)
        ST_OS: begin
          if (enable && w_isUser && !w_fault) begin
            r_state   <= ST_RUN;
            r_quantum <= w_quantumInit;
          end
        end
        ST_RUN: begin
          if (enable) begin
            r_quantum <= r_quantum - QW'(1);
            if (w_trapReq) begin
              r_state      <= ST_TRAP;
              r_trapCause  <= w_cause;
              r_trapVector <= w_vector;
              r_savedPc    <= w_savedPc;
            end else if (!w_isUser) begin
              r_state   <= ST_OS;
              r_quantum <= '0;
            end
          end
        end
        ST_TRAP: begin
          if (trap_ack) begin
            r_state     <= ST_OS;
            r_trapCause <= CAUSE_NONE;
            r_quantum   <= '0;
          end
        end
        default: r_state <= ST_OS;
      endcase
    end
  end

  assign trap_valid   = (r_state == ST_TRAP);
  assign trap_vector  = r_trapVector;
  assign trap_cause   = r_trapCause;
  assign saved_pc     = r_savedPc;
  assign proc_id      = r_procId;
  assign quantum_left = r_quantum;
  assign in_user      = (r_state == ST_RUN);

endmodule
